rgmii_rx: RTL and testbench

Byte-level Ethernet frame receiver for the RGMII link; the receive-side counterpart of the fixed-frame `tx` path. It sits after the DDR input capture, which delivers one byte per `clk125` cycle. The block:
- detects preamble/SFD;
- filters on destination MAC and EtherType;
- streams payload bytes with the FCS stripped;
- checks CRC-32 and length;
- reports a per-frame pass/fail status with saturating error counters.

---
 rtl/rgmii_rx.sv | 203 ++++++++++++++++++++
 tb/tb_rgmii_rx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rgmii_rx.sv
// Byte-level RGMII receive path: preamble/SFD detection, MAC/EtherType filter,
// FCS-stripped payload streaming, CRC-32 and length checking with error counters.
module rgmii_rx #(
  parameter logic [47:0] LOCAL_MAC    = 48'h0088_dab8_bf08,
  parameter logic [15:0] ETHERTYPE    = 16'h1919,
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter int          MAX_PAYLOAD  = 1500
) (
  input  logic        clk125,
  input  logic        rst,
  input  logic        rxdv,
  input  logic        rxer,
  input  logic [7:0]  rxbyte,
  output logic [7:0]  odata,
  output logic        ovalid,
  output logic        done,
  output logic        ok,
  output logic [15:0] crc_err_cnt,
  output logic [15:0] len_err_cnt
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, DROP} state_t;

  localparam logic [10:0] P_MAX   = 11'(MAX_PAYLOAD + 4);
  localparam logic [10:0] P_MIN   = 11'd50;
  localparam logic [31:0] CRC_RES = 32'hDEBB20E3;

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t          state_q, state_d;
  logic [3:0]      hcnt_q, hcnt_d;
  logic            uc_ok_q, uc_ok_d, bc_ok_q, bc_ok_d;
  logic [31:0]     crc_q, crc_d;
  logic [10:0]     pcnt_q, pcnt_d;
  logic [3:0][7:0] dl_q, dl_d;
  logic            rxer_seen_q, rxer_seen_d;
  logic            dv_prev_q, dv_prev_d;
  logic [7:0]      odata_q, odata_d;
  logic            ovalid_q, ovalid_d, done_q, done_d, ok_q, ok_d;
  logic [15:0]     crc_err_q, crc_err_d, len_err_q, len_err_d;

  logic [31:0] crc_nxt;
  logic [10:0] pcnt_inc;
  logic [47:0] mac_sh;
  logic        sfd, uc_hit, bc_hit, crc_pass, len_ok;

  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    uc_ok_d     = uc_ok_q;
    bc_ok_d     = bc_ok_q;
    crc_d       = crc_q;
    pcnt_d      = pcnt_q;
    dl_d        = dl_q;
    rxer_seen_d = rxer_seen_q;
    dv_prev_d   = rxdv;
    odata_d     = odata_q;
    ovalid_d    = 1'b0;
    done_d      = 1'b0;
    ok_d        = 1'b0;
    crc_err_d   = crc_err_q;
    len_err_d   = len_err_q;
    sfd         = 1'b0;
    uc_hit      = 1'b0;
    bc_hit      = 1'b0;
    crc_pass    = (crc_q == CRC_RES);
    len_ok      = (pcnt_q >= P_MIN) && (pcnt_q <= P_MAX);
    crc_nxt     = crc_next(crc_q, rxbyte);
    pcnt_inc    = (pcnt_q == 11'h7FF) ? pcnt_q : pcnt_q + 11'd1;
    mac_sh      = LOCAL_MAC << {hcnt_q, 3'b000};

    case (state_q)
      IDLE: begin
        // Carrier already up when we got here (only after reset): never resync mid-frame.
        if (rxdv) begin
          if (dv_prev_q)             state_d = DROP;
          else if (rxbyte == 8'h55)  state_d = PREAMBLE;
          else if (rxbyte == 8'hd5)  sfd = 1'b1;
          else                       state_d = DROP;
        end
      end
      PREAMBLE: begin
        if (!rxdv)                  state_d = IDLE;
        else if (rxbyte == 8'hd5)   sfd = 1'b1;
        else if (rxbyte != 8'h55)   state_d = DROP;
      end
      HEADER: begin
        if (!rxdv) begin
          state_d   = IDLE;
          len_err_d = sat_inc16(len_err_q);
        end else begin
          crc_d  = crc_nxt;
          hcnt_d = hcnt_q + 4'd1;
          if (rxer) rxer_seen_d = 1'b1;
          if (hcnt_q < 4'd6) begin
            uc_hit  = uc_ok_q && (rxbyte == mac_sh[47:40]);
            bc_hit  = bc_ok_q && (rxbyte == 8'hff);
            uc_ok_d = uc_hit;
            bc_ok_d = bc_hit;
            if (!uc_hit && !bc_hit) state_d = DROP;
          end else if (hcnt_q == 4'd12 && rxbyte != ETHERTYPE[15:8]) begin
            state_d = DROP;
          end else if (hcnt_q == 4'd13) begin
            if (rxbyte != ETHERTYPE[7:0]) state_d = DROP;
            else begin
              state_d = PAYLOAD;
              pcnt_d  = 11'd0;
            end
          end
        end
      end
      PAYLOAD: begin
        if (rxdv) begin
          crc_d  = crc_nxt;
          pcnt_d = pcnt_inc;
          dl_d   = {dl_q[2:0], rxbyte};
          if (rxer) rxer_seen_d = 1'b1;
          // Oldest byte leaves the delay line only once four newer bytes exist.
          if (pcnt_q >= 11'd4 && pcnt_inc <= P_MAX) begin
            ovalid_d = 1'b1;
            odata_d  = dl_q[3];
          end
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
          ok_d    = crc_pass && len_ok && !rxer_seen_q;
          if (!crc_pass)                  crc_err_d = sat_inc16(crc_err_q);
          else if (!len_ok || rxer_seen_q) len_err_d = sat_inc16(len_err_q);
        end
      end
      DROP: begin
        if (!rxdv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (sfd) begin
      state_d     = HEADER;
      hcnt_d      = 4'd0;
      uc_ok_d     = 1'b1;
      bc_ok_d     = ACCEPT_BCAST;
      crc_d       = 32'hFFFFFFFF;
      rxer_seen_d = 1'b0;
    end
  end

  always_ff @(posedge clk125) begin
    if (rst) begin
      state_q     <= IDLE;
      hcnt_q      <= 4'd0;
      uc_ok_q     <= 1'b0;
      bc_ok_q     <= 1'b0;
      pcnt_q      <= 11'd0;
      dl_q        <= '0;
      rxer_seen_q <= 1'b0;
      dv_prev_q   <= 1'b1;
      odata_q     <= 8'd0;
      ovalid_q    <= 1'b0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      crc_err_q   <= 16'd0;
      len_err_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      uc_ok_q     <= uc_ok_d;
      bc_ok_q     <= bc_ok_d;
      pcnt_q      <= pcnt_d;
      dl_q        <= dl_d;
      rxer_seen_q <= rxer_seen_d;
      dv_prev_q   <= dv_prev_d;
      odata_q     <= odata_d;
      ovalid_q    <= ovalid_d;
      done_q      <= done_d;
      ok_q        <= ok_d;
      crc_err_q   <= crc_err_d;
      len_err_q   <= len_err_d;
    end
  end

  // CRC register is always seeded on SFD before it is consulted.
  always_ff @(posedge clk125) begin
    crc_q <= crc_d;
  end

  assign odata       = odata_q;
  assign ovalid      = ovalid_q;
  assign done        = done_q;
  assign ok          = ok_q;
  assign crc_err_cnt = crc_err_q;
  assign len_err_cnt = len_err_q;

endmodule

// File: tb/tb_rgmii_rx.sv
// Scoreboard bench for rgmii_rx: directed frames push expected payload bytes and
// end-of-frame status into queues; a negedge monitor pops and compares.
module tb_rgmii_rx;

  localparam logic [47:0] MAC   = 48'h0088_dab8_bf08;
  localparam logic [47:0] SRC   = 48'h0200_0000_0001;
  localparam logic [47:0] BCAST = 48'hffff_ffff_ffff;
  localparam logic [15:0] ET    = 16'h1919;

  logic        clk125 = 1'b0;
  logic        rst = 1'b1, rxdv = 1'b0, rxer = 1'b0;
  logic [7:0]  rxbyte = 8'd0;
  logic [7:0]  odata;
  logic        ovalid, done, ok;
  logic [15:0] crc_err_cnt, len_err_cnt;

  rgmii_rx dut (
    .clk125(clk125), .rst(rst), .rxdv(rxdv), .rxer(rxer), .rxbyte(rxbyte),
    .odata(odata), .ovalid(ovalid), .done(done), .ok(ok),
    .crc_err_cnt(crc_err_cnt), .len_err_cnt(len_err_cnt)
  );

  always #4 clk125 = ~clk125;

  int cyc = 0;
  always @(posedge clk125) cyc <= cyc + 1;

  typedef struct { logic [7:0] val; int cyc; } exp_b_t;
  typedef struct { logic ok; int cyc; } exp_d_t;
  exp_b_t qb[$];
  exp_d_t qd[$];
  exp_b_t eb;
  exp_d_t ed;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_crc = 16'd0, exp_len = 16'd0;
  logic [7:0]  frame_q[$];

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Builds preamble, SFD, header, payload (pay + k*incr) and FCS into frame_q.
  task automatic build_frame(input logic [47:0] dst, input logic [15:0] etype, input int plen,
                             input logic [7:0] pay, input logic [7:0] incr, input int pre_len,
                             input bit flip);
    logic [31:0] c;
    logic [7:0]  b;
    frame_q.delete();
    for (int i = 0; i < pre_len; i++) frame_q.push_back(8'h55);
    frame_q.push_back(8'hd5);
    for (int i = 0; i < 6; i++) frame_q.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frame_q.push_back(SRC[47-8*i -: 8]);
    frame_q.push_back(etype[15:8]);
    frame_q.push_back(etype[7:0]);
    for (int k = 0; k < plen; k++) begin
      b = pay + 8'(k) * incr;
      frame_q.push_back(b);
    end
    c = 32'hFFFFFFFF;
    for (int i = pre_len + 1; i < frame_q.size(); i++) c = crc_upd(c, frame_q[i]);
    c = ~c;
    if (flip) c = c ^ 32'h0000_0001;
    for (int i = 0; i < 4; i++) frame_q.push_back(c[8*i +: 8]);
  endtask

  task automatic send_frame(input logic [47:0] dst, input logic [15:0] etype, input int plen,
                            input logic [7:0] pay, input logic [7:0] incr, input int pre_len,
                            input bit flip, input int rxer_idx, input int max_bytes,
                            input bit accept, input bit exp_ok, input int gap);
    int n, k, pstart;
    build_frame(dst, etype, plen, pay, incr, pre_len, flip);
    pstart = pre_len + 15;
    n = (max_bytes < 0) ? frame_q.size() : max_bytes;
    for (int i = 0; i < n; i++) begin
      @(posedge clk125); #1;
      rxdv = 1'b1;
      rxbyte = frame_q[i];
      rxer = (i == rxer_idx);
      k = i - pstart;
      if (accept && k >= 0 && k < plen && k < 1500) qb.push_back('{frame_q[i], cyc + 5});
    end
    @(posedge clk125); #1;
    rxdv = 1'b0; rxer = 1'b0; rxbyte = 8'd0;
    if (accept) qd.push_back('{exp_ok, cyc + 1});
    repeat (gap - 1) @(posedge clk125);
  endtask

  task automatic check_counters(input string name);
    @(negedge clk125);
    checks += 2;
    if (crc_err_cnt !== exp_crc) begin
      failures++;
      $display("FAIL %s crc_err_cnt got %0d required %0d", name, crc_err_cnt, exp_crc);
    end
    if (len_err_cnt !== exp_len) begin
      failures++;
      $display("FAIL %s len_err_cnt got %0d required %0d", name, len_err_cnt, exp_len);
    end
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if (odata !== 8'd0 || ovalid !== 1'b0 || done !== 1'b0 || ok !== 1'b0) begin
      failures++;
      $display("FAIL %s outputs got odata=%h ovalid=%b done=%b ok=%b required all 0",
               name, odata, ovalid, done, ok);
    end
  endtask

  always @(negedge clk125) begin
    if (ovalid) begin
      checks++;
      if (qb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_byte got odata=%h at cyc %0d required no output", odata, cyc);
      end else begin
        eb = qb.pop_front();
        if (odata !== eb.val || cyc != eb.cyc) begin
          failures++;
          $display("FAIL payload_byte got %h at cyc %0d required %h at cyc %0d",
                   odata, cyc, eb.val, eb.cyc);
        end
      end
    end
    if (done) begin
      checks++;
      if (qd.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done got ok=%b at cyc %0d required no done", ok, cyc);
      end else begin
        ed = qd.pop_front();
        if (ok !== ed.ok || cyc != ed.cyc) begin
          failures++;
          $display("FAIL frame_status got ok=%b at cyc %0d required ok=%b at cyc %0d",
                   ok, cyc, ed.ok, ed.cyc);
        end
      end
    end
  end

  task automatic reset_mid_frame();
    int k;
    build_frame(MAC, ET, 100, 8'h10, 8'd1, 7, 1'b0);
    for (int i = 0; i < frame_q.size(); i++) begin
      @(posedge clk125); #1;
      rxdv = 1'b1;
      rxbyte = frame_q[i];
      k = i - 22;
      if (k == 30) rst = 1'b1;
      if (k == 32) rst = 1'b0;
      if (k >= 0 && k <= 25) qb.push_back('{frame_q[i], cyc + 5});
      if (k == 31) begin
        check_quiet("reset_mid_payload");
        checks++;
        if (crc_err_cnt !== 16'd0 || len_err_cnt !== 16'd0) begin
          failures++;
          $display("FAIL reset_counters got crc=%0d len=%0d required 0 0", crc_err_cnt, len_err_cnt);
        end
      end
    end
    @(posedge clk125); #1;
    rxdv = 1'b0; rxbyte = 8'd0;
    exp_crc = 16'd0;
    exp_len = 16'd0;
    repeat (4) @(posedge clk125);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk125);
    #1 rst = 1'b0;
    @(negedge clk125);
    check_quiet("reset_state");
    check_counters("reset_state");

    // dst, type, plen, pay, incr, pre, flip, rxer_idx, max, accept, ok, gap
    send_frame(MAC, ET, 200, 8'h39, 8'd0, 7, 0, -1, -1, 1, 1, 4);
    check_counters("good_frame");
    send_frame(MAC, ET, 200, 8'h39, 8'd0, 7, 1, -1, -1, 1, 0, 4);
    exp_crc = 16'd1;
    check_counters("fcs_flip");
    send_frame(48'h0088_dab8_bf09, ET, 60, 8'h39, 8'd0, 7, 0, -1, -1, 0, 0, 4);
    check_counters("wrong_mac");
    send_frame(BCAST, ET, 60, 8'h21, 8'd3, 7, 0, -1, -1, 1, 1, 4);
    check_counters("broadcast");
    send_frame(MAC, ET, 10, 8'h05, 8'd1, 7, 0, -1, -1, 1, 0, 4);
    exp_len = 16'd1;
    check_counters("runt_10");
    send_frame(MAC, ET, 1501, 8'h00, 8'd7, 7, 0, -1, -1, 1, 0, 4);
    exp_len = 16'd2;
    check_counters("oversize_1501");
    send_frame(MAC, ET, 100, 8'h40, 8'd1, 7, 0, 72, -1, 1, 0, 4);
    exp_len = 16'd3;
    check_counters("rxer_mid_payload");
    send_frame(MAC, 16'h0800, 60, 8'h39, 8'd0, 7, 0, -1, -1, 0, 0, 4);
    check_counters("wrong_ethertype");
    send_frame(MAC, ET, 60, 8'h39, 8'd0, 7, 0, -1, 16, 0, 0, 4);
    exp_len = 16'd4;
    check_counters("header_truncated");
    send_frame(MAC, ET, 64, 8'h80, 8'd5, 0, 0, -1, -1, 1, 1, 4);
    check_counters("no_preamble");
    send_frame(MAC, ET, 46, 8'h11, 8'd1, 7, 0, -1, -1, 1, 1, 4);
    check_counters("min_payload_46");
    send_frame(MAC, ET, 45, 8'h11, 8'd1, 7, 0, -1, -1, 1, 0, 4);
    exp_len = 16'd5;
    check_counters("short_payload_45");
    send_frame(MAC, ET, 1500, 8'h03, 8'd11, 7, 0, -1, -1, 1, 1, 4);
    check_counters("max_payload_1500");

    reset_mid_frame();
    send_frame(MAC, ET, 80, 8'h39, 8'd0, 7, 0, -1, -1, 1, 1, 4);
    check_counters("after_reset");

    send_frame(MAC, ET, 200, 8'h39, 8'd0, 7, 0, -1, -1, 1, 1, 1);
    send_frame(MAC, ET, 200, 8'h39, 8'd0, 7, 0, -1, -1, 1, 1, 4);
    check_counters("back_to_back");

    for (int i = 0; i < 50 && (qb.size() != 0 || qd.size() != 0); i++) @(posedge clk125);
    checks += 2;
    if (qb.size() != 0) begin
      failures++;
      $display("FAIL missing_bytes got %0d still pending required 0", qb.size());
    end
    if (qd.size() != 0) begin
      failures++;
      $display("FAIL missing_done got %0d still pending required 0", qd.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
